// File: rtl/frame_capture_writer.sv
// Packs a grayscale pixel stream two-per-word and writes one frame to SRAM, then pulses match_start.
// Optional build macro BINARIZE_EN thresholds each pixel to 8'h00/8'hFF before packing.
module frame_capture_writer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 8,
    parameter int BIN_THRESH = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_req,
    input  logic [19:0] base_addr,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [7:0]  pix_data,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wr,
    input  logic        mem_ready,
    output logic        match_start,
    output logic        busy,
    output logic        overflow
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_PIX = CW'(NPIX - 1);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE} state_t;
    state_t state, state_nx;

    logic [19:0]   base_lat;
    logic [CW-1:0] pix_cnt;
    logic [CW-1:0] word_idx;
    logic [7:0]    pack_reg;
    logic [7:0]    pix_in;
    logic          push_vld;
    logic [15:0]   push_word;
    logic [19:0]   push_addr;

    logic [15:0]   fifo_data [FIFO_DEPTH];
    logic [19:0]   fifo_addr [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [AW:0]   count, count_left, count_nx;
    logic          accept, last_pix, pop, full, push_ok;

    function automatic logic [7:0] pix_xform(input logic [7:0] p);
`ifdef BINARIZE_EN
        return (int'(p) >= BIN_THRESH) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    assign accept      = pix_valid && ((state == S_CAPTURE) || (state == S_ARMED && frame_start));
    assign last_pix    = accept && (pix_cnt == LAST_PIX);
    assign pix_in      = pix_xform(pix_data);
    assign pop         = mem_wr && mem_ready;
    assign full        = (count == (AW+1)'(FIFO_DEPTH));
    // A push into a full FIFO survives only if the head leaves in the same cycle.
    assign push_ok     = push_vld && (!full || pop);
    assign count_left  = count - (AW+1)'(pop);
    assign count_nx    = count_left + (AW+1)'(push_ok);
    assign rd_ptr_nx   = rd_ptr + AW'(pop);
    assign busy        = (state != S_IDLE);
    assign match_start = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (cap_req) state_nx = S_ARMED;
            S_ARMED:   if (frame_start) state_nx = S_CAPTURE;
            S_CAPTURE: if (last_pix) state_nx = S_DRAIN;
            S_DRAIN:   if (!push_vld && (count == '0 || (count == (AW+1)'(1) && pop))) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data[wr_ptr] <= push_word;
            fifo_addr[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            base_lat  <= '0;
            pix_cnt   <= '0;
            word_idx  <= '0;
            pack_reg  <= '0;
            push_vld  <= 1'b0;
            push_word <= '0;
            push_addr <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && cap_req) begin
                base_lat <= base_addr;
                overflow <= 1'b0;
                pix_cnt  <= '0;
                word_idx <= '0;
            end

            // Pack stage: even pixel waits, odd pixel completes a word for next-cycle push.
            push_vld <= 1'b0;
            if (accept) begin
                pix_cnt <= pix_cnt + 1'b1;
                if (!pix_cnt[0]) begin
                    pack_reg <= pix_in;
                end else begin
                    push_vld  <= 1'b1;
                    push_word <= {pix_in, pack_reg};
                    push_addr <= base_lat + 20'(word_idx);
                    word_idx  <= word_idx + 1'b1;
                end
            end

            // FIFO stage: dropped words still consumed their index above.
            if (push_vld && !push_ok) overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nx;
            count  <= count_nx;

            // Output stage: present the post-update head; bypass when it is the word being pushed.
            mem_wr <= (count_nx != '0);
            if (count_left == '0) begin
                mem_data <= push_word;
                mem_addr <= push_addr;
            end else begin
                mem_data <= fifo_data[rd_ptr_nx];
                mem_addr <= fifo_addr[rd_ptr_nx];
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_writer.sv
// Scoreboard bench for frame_capture_writer: randomized frames against a word-level reference model.
module tb_frame_capture_writer;

    localparam int IMG_W      = 4;
    localparam int IMG_H      = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int BIN_THRESH = 128;
    localparam int NPIX       = IMG_W * IMG_H;
    localparam int NWORD      = NPIX / 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cap_req = 1'b0;
    logic [19:0] base_addr = '0;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        mem_ready = 1'b1;
    logic [19:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wr;
    logic        match_start;
    logic        busy;
    logic        overflow;

    frame_capture_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(FIFO_DEPTH), .BIN_THRESH(BIN_THRESH)
    ) dut (
        .clk(clk), .rst(rst), .cap_req(cap_req), .base_addr(base_addr),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr), .mem_ready(mem_ready),
        .match_start(match_start), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_hs = -10;
    int ms_count = 0;
    int wr_count = 0;
    int ready_mode = 1;          // 0 hold low, 1 always high, 2 random, 3 stall one address
    logic [19:0] stall_addr = '0;
    int stall_left = 0;
    logic [7:0]  px [NPIX];
    logic [19:0] q_addr [$];
    logic [15:0] q_data [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xf(input logic [7:0] p);
`ifdef BINARIZE_EN
        return (int'(p) >= BIN_THRESH) ? 8'hFF : 8'h00;
`else
        return p;
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: mem_ready = 1'b0;
            2: mem_ready = ($urandom_range(0, 3) != 0);
            3: begin
                if (mem_wr && mem_addr == stall_addr && stall_left > 0) begin
                    mem_ready = 1'b0;
                    stall_left--;
                end else begin
                    mem_ready = 1'b1;
                end
            end
            default: mem_ready = 1'b1;
        endcase
    end

    // Monitor: write handshakes against the expected queue, stall stability, match_start timing.
    logic        prev_stall = 1'b0;
    logic        prev_ms = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [15:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            prev_ms = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_wr", 32'(mem_wr), 32'd1);
                check("hold_addr", 32'(mem_addr), 32'(prev_addr));
                check("hold_data", 32'(mem_data), 32'(prev_data));
            end
            if (mem_wr && mem_ready) begin
                wr_count++;
                last_hs = cyc;
                while (q_addr.size() > 1 && overflow && q_addr[0] !== mem_addr) begin
                    void'(q_addr.pop_front());
                    void'(q_data.pop_front());
                end
                if (q_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_data);
                end else begin
                    check("wr_addr", 32'(mem_addr), 32'(q_addr.pop_front()));
                    check("wr_data", 32'(mem_data), 32'(q_data.pop_front()));
                end
            end
            if (match_start) begin
                ms_count++;
                check("ms_after_last_write", 32'(cyc), 32'(last_hs + 1));
                check("ms_single_cycle", 32'(prev_ms), 32'd0);
            end
            prev_stall = mem_wr && !mem_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_data;
            prev_ms    = match_start;
        end
    end

    task automatic run_frame(input logic [19:0] base, input int rmode, input bit rand_valid,
                             input bit fs_with_pix, input bit ovf_known, input bit exp_ovf,
                             input int exp_writes);
        int i;
        int ms0;
        int wr0;
        int waited;
        logic [19:0] a;
        ready_mode = rmode;
        stall_addr = base + 20'd1;
        stall_left = 3;
        ms0 = ms_count;
        wr0 = wr_count;
        @(posedge clk); #1;
        cap_req = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        cap_req = 1'b0;
        base_addr = 20'($urandom);
        check("busy_armed", 32'(busy), 32'd1);
        check("ovf_cleared", 32'(overflow), 32'd0);
        pix_valid = 1'b1;            // ignored while ARMED without frame_start
        pix_data = 8'hEE;
        @(posedge clk); #1;
        frame_start = 1'b1;
        i = 0;
        if (fs_with_pix) begin
            pix_valid = 1'b1;
            pix_data = px[0];
            i = 1;
        end else begin
            pix_valid = 1'b0;
        end
        while (i < NPIX) begin
            @(posedge clk); #1;
            frame_start = 1'b0;
            cap_req = 1'b0;
            if (i == 3) begin
                frame_start = 1'b1;  // both ignored mid-capture
                cap_req = 1'b1;
                base_addr = 20'h55555;
            end
            pix_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pix_valid) begin
                pix_data = px[i];
                if (i % 2 == 1) begin
                    a = base + 20'(i / 2);
                    q_addr.push_back(a);
                    q_data.push_back({xf(px[i]), xf(px[i-1])});
                end
                i++;
            end
        end
        @(posedge clk); #1;
        pix_valid = 1'b0;
        frame_start = 1'b0;
        cap_req = 1'b0;
        if (rmode == 0) begin
            repeat (6) @(posedge clk);
            #1;
            ready_mode = 1;
        end
        waited = 0;
        while (ms_count == ms0 && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        if (ms_count == ms0) begin
            n_tests++;
            n_fail++;
            $display("FAIL match_start_timeout: got no pulse, required one within 300 cycles");
        end else begin
            check("busy_after_done", 32'(busy), 32'd0);
            check("ms_low_after_done", 32'(match_start), 32'd0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("ms_pulse_count", 32'(ms_count - ms0), 32'd1);
        if (ovf_known) check("overflow", 32'(overflow), 32'(exp_ovf));
        if (exp_writes >= 0) begin
            check("write_count", 32'(wr_count - wr0), 32'(exp_writes));
            check("dropped_words", 32'(q_addr.size()), 32'(NWORD - exp_writes));
        end else if (!overflow) begin
            check("queue_drained", 32'(q_addr.size()), 32'd0);
        end
        q_addr.delete();
        q_data.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
        $fatal(1);
    end

    initial begin
        int ms0;
        int wr0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_match_start", 32'(match_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int k = 0; k < NPIX; k++) px[k] = 8'(k + 1);
        run_frame(20'h00100, 1, 1'b0, 1'b1, 1'b1, 1'b0, NWORD);
        run_frame(20'h00100, 3, 1'b0, 1'b1, 1'b1, 1'b0, NWORD);
        run_frame(20'h00200, 0, 1'b0, 1'b1, 1'b1, 1'b1, FIFO_DEPTH);
        run_frame(20'hFFFFE, 1, 1'b0, 1'b0, 1'b1, 1'b0, NWORD);
        px[0] = 8'h7F;
        px[1] = 8'h80;
        run_frame(20'h00400, 1, 1'b1, 1'b1, 1'b1, 1'b0, NWORD);

        // Abort mid-capture: no writes and no match_start afterwards.
        ms0 = ms_count;
        wr0 = wr_count;
        ready_mode = 0;
        @(posedge clk); #1;
        cap_req = 1'b1;
        base_addr = 20'h00300;
        @(posedge clk); #1;
        cap_req = 1'b0;
        frame_start = 1'b1;
        pix_valid = 1'b1;
        pix_data = 8'h11;
        @(posedge clk); #1;
        frame_start = 1'b0;
        pix_data = 8'h22;
        @(posedge clk); #1;
        pix_data = 8'h33;
        @(posedge clk); #1;
        rst = 1'b0;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_data", 32'(mem_data), 32'd0);
        check("abort_mem_wr", 32'(mem_wr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        rst = 1'b1;
        ready_mode = 1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_match_start", 32'(ms_count - ms0), 32'd0);
        check("abort_no_writes", 32'(wr_count - wr0), 32'd0);

        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < NPIX; k++) px[k] = 8'($urandom);
            if (f % 4 == 0)
                run_frame(20'($urandom), 1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0, NWORD);
            else
                run_frame(20'($urandom), 2, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
